usb_data_buffer: RTL and testbench
==================================

// Module: usb_data_buffer
// PURPOSE
//   64-byte circular data FIFO between the USB packet engines (usb_rx / usb_tx) and
//   the AHB-Lite slave in usb_ahb. Byte-wide USB side: RX stores, TX fetches.
//   Word-wide AHB side: 1/2/4-byte stores and fetches, little-endian. One shared
//   buffer, one transfer direction at a time. Exports occupancy for status registers.
// PARAMETERS
//   DEPTH   64  buffer size in bytes; power of 2, >= 4
//   PTR_W   $clog2(DEPTH)+1  pointer width incl. wrap bit (derived, do not override)
// PORTS
//   clk                    in   1      system clock, rising edge
//   rst                    in   1      asynchronous, active-high reset
//   clear                  in   1      synchronous flush of all contents
//   store_rx_packet_data   in   1      push rx_packet_data (usb_rx side)
//   rx_packet_data         in   8      byte from usb_rx
//   get_tx_packet_data     in   1      pop one byte (usb_tx side)
//   tx_packet_data         out  8      byte at head; 0 when empty
//   store_tx_data          in   1      AHB push of tx_size bytes
//   tx_data                in   32     AHB write data, byte 0 in [7:0]
//   tx_size                in   2      0=1B 1=2B 2=4B; 3=illegal
//   get_rx_data            in   1      AHB pop of rx_size bytes
//   rx_size                in   2      0=1B 1=2B 2=4B; 3=illegal
//   rx_data                out  32     head bytes, unused lanes 0; 0 when empty
//   buffer_occupancy       out  7      bytes held, 0..DEPTH
//   buffer_empty           out  1      occupancy == 0
//   buffer_full            out  1      occupancy == DEPTH
//   buffer_err             out  1      one-cycle pulse on rejected access
// BEHAVIOUR
//   - One clock, async active-high rst. Reset: wptr=rptr=0, occupancy 0, err 0,
//     all outputs 0 except buffer_empty=1. Memory contents not reset.
//   - Asserting rst mid-transfer discards everything, same state as power-up.
//   - Pointers are PTR_W bits; index = ptr[PTR_W-2:0], wrap automatic.
//     Occupancy = wptr - rptr (mod 2^PTR_W).
//   - Priority each cycle: clear > AHB access > USB access on the same side.
//     clear: wptr=rptr=0 next cycle. Other requests that cycle are ignored, no err.
//   - Write side: store_tx_data and store_rx_packet_data together -> AHB accepted,
//     USB byte dropped, buffer_err=1.
//   - Read side: get_rx_data and get_tx_packet_data together -> AHB accepted,
//     USB pop dropped, buffer_err=1.
//   - Write of N bytes accepted iff occupancy_after_same_cycle_pop + N <= DEPTH.
//     Otherwise no bytes written, err=1. No partial writes.
//   - Read of N bytes accepted iff occupancy >= N. Otherwise rptr unchanged, err=1.
//     rx_data shows the available bytes anyway, zero-filled.
//   - Size 3 on an active request: rejected, err=1.
//   - Simultaneous accepted push and pop: legal. occupancy += Nw - Nr. A pop from
//     empty is rejected even with a same-cycle push (no bypass).
//   - Read data is combinational from mem at rptr, first-word-fall-through:
//     rx_data[8k+7:8k] = mem[rptr+k] for k<min(N,occupancy), else 0.
//   - Written data is visible on the cycle after the store edge.
//   - Multi-byte write: tx_data[8k+7:8k] goes to mem[wptr+k]; wraps across DEPTH.
//   - Status flags and occupancy are registered-state derived; they update the
//     cycle after the access.
// STRUCTURE
//   - usb_pkg (shared): typedef enum logic[1:0] {SZ_1B, SZ_2B, SZ_4B, SZ_BAD}
//     xfer_size_t; localparam USB_BUF_DEPTH=64; function size_bytes(xfer_size_t).
//   - Single module. Byte array mem[DEPTH], two pointer registers, one err register.
//   - No sub-module: the lane/wrap logic is a generate loop over 4 byte lanes.
// TESTING
//   1 reset: rst=1 mid-write of 0xA5 -> occupancy 0, empty=1, rx_data=0,
//     tx_packet_data=0.
//   2 RX path: push bytes 01,02,03,04,05 via store_rx_packet_data; get_rx_data
//     SZ_4B -> rx_data=0x04030201, occ 5->1; then SZ_2B -> rx_data=0x00000005,
//     err=1, occ stays 1.
//   3 TX path + wrap: prefill and drain 62 bytes, then store_tx_data 0xDDCCBBAA
//     SZ_4B (wptr 62->2) -> four pops give AA,BB,CC,DD, then empty=1.
//   4 full/overflow: 64 single-byte pushes -> full=1, occ=64; a 65th push -> err=1,
//     contents unchanged. Same cycle push+pop at full is accepted, occ stays 64.
//   5 conflicts: store_tx_data and store_rx_packet_data in one cycle -> only AHB
//     word stored, err=1. clear together with push -> occ 0, err=0.
//   6 illegal size: get_rx_data with rx_size=3 on occupancy 8 -> err=1, occ 8.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared USB definitions: AHB transfer size encoding, default data buffer depth and a helper
// that maps a transfer size code to its byte count.
package usb_pkg;

  typedef enum logic [1:0] {
    SZ_1B  = 2'd0,
    SZ_2B  = 2'd1,
    SZ_4B  = 2'd2,
    SZ_BAD = 2'd3
  } xfer_size_t;

  localparam int unsigned USB_BUF_DEPTH = 64;

  // Byte count of a transfer; 0 marks the illegal encoding.
  function automatic logic [2:0] size_bytes(xfer_size_t sz);
    logic [2:0] n;
    case (sz)
      SZ_1B:   n = 3'd1;
      SZ_2B:   n = 3'd2;
      SZ_4B:   n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/usb_data_buffer.sv
// Circular byte FIFO shared between the USB packet engines and the AHB slave.
//   clk, rst                      clock, asynchronous active-high reset
//   clear                         synchronous flush (wins over every other request)
//   store_rx_packet_data,
//   rx_packet_data[7:0]           usb_rx byte push
//   get_tx_packet_data,
//   tx_packet_data[7:0]           usb_tx byte pop / head byte (0 when empty)
//   store_tx_data, tx_data[31:0],
//   tx_size[1:0]                  AHB push of 1/2/4 bytes, little-endian
//   get_rx_data, rx_size[1:0],
//   rx_data[31:0]                 AHB pop of 1/2/4 bytes / head bytes, missing lanes 0
//   buffer_occupancy, buffer_empty,
//   buffer_full, buffer_err       status; err is a one-cycle pulse on a rejected access
module usb_data_buffer
  import usb_pkg::*;
#(
  parameter int unsigned DEPTH = USB_BUF_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             store_rx_packet_data,
  input  logic [7:0]       rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [7:0]       tx_packet_data,
  input  logic             store_tx_data,
  input  logic [31:0]      tx_data,
  input  logic [1:0]       tx_size,
  input  logic             get_rx_data,
  input  logic [1:0]       rx_size,
  output logic [31:0]      rx_data,
  output logic [PTR_W-1:0] buffer_occupancy,
  output logic             buffer_empty,
  output logic             buffer_full,
  output logic             buffer_err
);

  localparam int unsigned IDX_W = PTR_W - 1;
  localparam logic [PTR_W:0] DEPTH_EXT = (PTR_W + 1)'(DEPTH);

  logic [7:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic             err_q, err_d;
  logic [PTR_W-1:0] occ;

  xfer_size_t wr_sz, rd_sz;
  logic       rd_req, wr_req, rd_ok, wr_ok;
  logic [2:0] rd_need, wr_need, nr, nw, rx_n;
  logic [PTR_W:0] occ_after_pop, occ_after_push;

  logic [IDX_W-1:0] wr_idx  [4];
  logic [7:0]       wr_byte [4];
  logic [3:0]       wr_en;

  assign occ   = wptr_q - rptr_q;
  assign wr_sz = xfer_size_t'(tx_size);
  assign rd_sz = xfer_size_t'(rx_size);
  assign rx_n  = size_bytes(rd_sz);

  always_comb begin
    rd_req  = get_rx_data | get_tx_packet_data;
    wr_req  = store_tx_data | store_rx_packet_data;
    // AHB wins a same-side conflict, so its size governs the access.
    rd_need = get_rx_data ? size_bytes(rd_sz) : 3'd1;
    wr_need = store_tx_data ? size_bytes(wr_sz) : 3'd1;

    // Pops only see registered occupancy: no same-cycle bypass from a push.
    rd_ok = rd_req && (rd_need != 3'd0) && (occ >= PTR_W'(rd_need));
    nr    = rd_ok ? rd_need : 3'd0;

    // Room check accounts for bytes freed by an accepted pop in the same cycle.
    occ_after_pop  = (PTR_W + 1)'(occ) - (PTR_W + 1)'(nr);
    occ_after_push = occ_after_pop + (PTR_W + 1)'(wr_need);
    wr_ok = wr_req && (wr_need != 3'd0) && (occ_after_push <= DEPTH_EXT);
    nw    = wr_ok ? wr_need : 3'd0;

    err_d = (rd_req && !rd_ok) || (get_rx_data && get_tx_packet_data) ||
            (wr_req && !wr_ok) || (store_tx_data && store_rx_packet_data);

    wptr_d = wptr_q + PTR_W'(nw);
    rptr_d = rptr_q + PTR_W'(nr);

    if (clear) begin
      nw     = 3'd0;
      nr     = 3'd0;
      err_d  = 1'b0;
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      err_q  <= err_d;
    end
  end

  // Per-lane addressing; the index width makes wrap across DEPTH automatic.
  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [IDX_W-1:0] rd_idx;

    assign wr_idx[k]  = wptr_q[IDX_W-1:0] + IDX_W'(k);
    assign wr_byte[k] = store_tx_data ? tx_data[8*k +: 8] : rx_packet_data;
    assign wr_en[k]   = (nw > 3'(k));

    assign rd_idx = rptr_q[IDX_W-1:0] + IDX_W'(k);
    assign rx_data[8*k +: 8] = ((3'(k) < rx_n) && (PTR_W'(k) < occ)) ? mem[rd_idx] : 8'h00;
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_en[k]) mem[wr_idx[k]] <= wr_byte[k];
    end
  end

  assign tx_packet_data   = (occ != '0) ? mem[rptr_q[IDX_W-1:0]] : 8'h00;
  assign buffer_occupancy = occ;
  assign buffer_empty     = (occ == '0);
  assign buffer_full      = (occ == PTR_W'(DEPTH));
  assign buffer_err       = err_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
// Self-checking bench for usb_data_buffer: directed scenarios followed by random traffic,
// all checked against a byte-queue reference model.
module tb_usb_data_buffer;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        store_rx_packet_data = 1'b0;
  logic [7:0]  rx_packet_data = 8'h00;
  logic        get_tx_packet_data = 1'b0;
  logic [7:0]  tx_packet_data;
  logic        store_tx_data = 1'b0;
  logic [31:0] tx_data = 32'h0;
  logic [1:0]  tx_size = 2'd0;
  logic        get_rx_data = 1'b0;
  logic [1:0]  rx_size = 2'd0;
  logic [31:0] rx_data;
  logic [6:0]  buffer_occupancy;
  logic        buffer_empty;
  logic        buffer_full;
  logic        buffer_err;

  usb_data_buffer dut (
    .clk                  (clk),
    .rst                  (rst),
    .clear                (clear),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .tx_size              (tx_size),
    .get_rx_data          (get_rx_data),
    .rx_size              (rx_size),
    .rx_data              (rx_data),
    .buffer_occupancy     (buffer_occupancy),
    .buffer_empty         (buffer_empty),
    .buffer_full          (buffer_full),
    .buffer_err           (buffer_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [7:0] q[$];
  logic       exp_err = 1'b0;
  logic [31:0] pre_rx;
  logic [7:0]  pre_tx;

  function automatic int bytes_of(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_rx(input logic [1:0] s);
    logic [31:0] v = 32'h0;
    for (int k = 0; k < bytes_of(s); k++)
      if (k < q.size()) v[8*k +: 8] = q[k];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_occ"},   32'(buffer_occupancy), 32'(q.size()));
    chk({tag, "_empty"}, 32'(buffer_empty),     32'(q.size() == 0));
    chk({tag, "_full"},  32'(buffer_full),      32'(q.size() == DEPTH));
    chk({tag, "_err"},   32'(buffer_err),       32'(exp_err));
    chk({tag, "_tx"},    32'(tx_packet_data),   32'(q.size() != 0 ? q[0] : 8'h00));
    chk({tag, "_rx"},    rx_data,               model_rx(rx_size));
  endtask

  // One clock of stimulus: drive at negedge, check head data, clock, update model, check.
  task automatic cycle(input logic clr, input logic srx, input logic [7:0] rxb, input logic gtx,
                       input logic stx, input logic [31:0] txd, input logic [1:0] txs,
                       input logic grx, input logic [1:0] rxs);
    int nr, nw, need;
    @(negedge clk);
    clear = clr; store_rx_packet_data = srx; rx_packet_data = rxb; get_tx_packet_data = gtx;
    store_tx_data = stx; tx_data = txd; tx_size = txs; get_rx_data = grx; rx_size = rxs;
    #1;
    pre_rx = rx_data;
    pre_tx = tx_packet_data;
    chk("pre_rx", pre_rx, model_rx(rxs));
    chk("pre_tx", 32'(pre_tx), 32'(q.size() != 0 ? q[0] : 8'h00));
    exp_err = 1'b0;
    nr = 0;
    nw = 0;
    if (clr) begin
      q.delete();
    end else begin
      if (grx || gtx) begin
        need = grx ? bytes_of(rxs) : 1;
        if (grx && gtx) exp_err = 1'b1;
        if (need == 0 || q.size() < need) exp_err = 1'b1;
        else nr = need;
      end
      if (stx || srx) begin
        need = stx ? bytes_of(txs) : 1;
        if (stx && srx) exp_err = 1'b1;
        if (need == 0 || q.size() - nr + need > DEPTH) exp_err = 1'b1;
        else nw = need;
      end
      for (int k = 0; k < nr; k++) void'(q.pop_front());
      for (int k = 0; k < nw; k++) q.push_back(stx ? txd[8*k +: 8] : rxb);
    end
    @(posedge clk);
    #1;
    chk_state("post");
  endtask

  task automatic idle();                         cycle(0, 0, 8'h0, 0, 0, 32'h0, 2'd0, 0, 2'd2); endtask
  task automatic do_clear();                     cycle(1, 0, 8'h0, 0, 0, 32'h0, 2'd0, 0, 2'd2); endtask
  task automatic push_rx(input logic [7:0] b);   cycle(0, 1, b,    0, 0, 32'h0, 2'd0, 0, 2'd2); endtask
  task automatic pop_tx();                       cycle(0, 0, 8'h0, 1, 0, 32'h0, 2'd0, 0, 2'd2); endtask
  task automatic ahb_rd(input logic [1:0] s);    cycle(0, 0, 8'h0, 0, 0, 32'h0, 2'd0, 1, s);    endtask
  task automatic ahb_wr(input logic [31:0] d, input logic [1:0] s);
    cycle(0, 0, 8'h0, 0, 1, d, s, 0, 2'd2);
  endtask

  initial begin
    rx_size = 2'd2;
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: reset asserted in the middle of a write
    push_rx(8'h11);
    push_rx(8'h22);
    @(negedge clk);
    store_rx_packet_data = 1'b1;
    rx_packet_data = 8'hA5;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    exp_err = 1'b0;
    chk_state("t1_rst");
    chk("t1_rx", rx_data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    store_rx_packet_data = 1'b0;
    idle();

    // 2: RX path, 4-byte pop then short 2-byte pop
    for (int i = 1; i <= 5; i++) push_rx(8'(i));
    ahb_rd(2'd2);
    chk("t2_rx4", pre_rx, 32'h04030201);
    chk("t2_occ1", 32'(buffer_occupancy), 32'd1);
    ahb_rd(2'd1);
    chk("t2_rx2", pre_rx, 32'h00000005);
    chk("t2_err", 32'(buffer_err), 32'd1);
    chk("t2_occ", 32'(buffer_occupancy), 32'd1);

    // 3: TX path with wrap of a 4-byte AHB store
    do_clear();
    for (int i = 0; i < 62; i++) push_rx(8'(i + 8'h40));
    for (int i = 0; i < 62; i++) pop_tx();
    ahb_wr(32'hDDCCBBAA, 2'd2);
    pop_tx();
    chk("t3_b0", 32'(pre_tx), 32'hAA);
    pop_tx();
    chk("t3_b1", 32'(pre_tx), 32'hBB);
    pop_tx();
    chk("t3_b2", 32'(pre_tx), 32'hCC);
    pop_tx();
    chk("t3_b3", 32'(pre_tx), 32'hDD);
    chk("t3_empty", 32'(buffer_empty), 32'd1);

    // 4: fill, overflow, push+pop at full
    do_clear();
    for (int i = 0; i < DEPTH; i++) push_rx(8'(i + 1));
    chk("t4_full", 32'(buffer_full), 32'd1);
    push_rx(8'hEE);
    chk("t4_ovf_err", 32'(buffer_err), 32'd1);
    chk("t4_ovf_occ", 32'(buffer_occupancy), 32'd64);
    ahb_wr(32'h12345678, 2'd0);
    chk("t4_ahb_ovf_err", 32'(buffer_err), 32'd1);
    cycle(0, 1, 8'h99, 1, 0, 32'h0, 2'd0, 0, 2'd2);
    chk("t4_pp_occ", 32'(buffer_occupancy), 32'd64);
    chk("t4_pp_err", 32'(buffer_err), 32'd0);
    chk("t4_pp_head", 32'(tx_packet_data), 32'h02);

    // 5: write-side conflict and clear priority
    do_clear();
    cycle(0, 1, 8'h77, 0, 1, 32'h44332211, 2'd2, 0, 2'd2);
    chk("t5_conf_err", 32'(buffer_err), 32'd1);
    chk("t5_conf_occ", 32'(buffer_occupancy), 32'd4);
    chk("t5_conf_rx", rx_data, 32'h44332211);
    cycle(0, 0, 8'h0, 1, 0, 32'h0, 2'd0, 1, 2'd0);
    chk("t5_rconf_err", 32'(buffer_err), 32'd1);
    cycle(1, 1, 8'h55, 0, 0, 32'h0, 2'd0, 0, 2'd2);
    chk("t5_clr_occ", 32'(buffer_occupancy), 32'd0);
    chk("t5_clr_err", 32'(buffer_err), 32'd0);

    // 6: illegal sizes
    for (int i = 0; i < 8; i++) push_rx(8'(8'hC0 + i));
    ahb_rd(2'd3);
    chk("t6_err", 32'(buffer_err), 32'd1);
    chk("t6_occ", 32'(buffer_occupancy), 32'd8);
    ahb_wr(32'hFFFFFFFF, 2'd3);
    chk("t6_wr_err", 32'(buffer_err), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      int r = int'($urandom_range(0, 99));
      cycle(r < 2,
            ($urandom_range(0, 99) < 35), 8'($urandom),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 30), $urandom, 2'($urandom_range(0, 99) < 5 ? 3 : $urandom_range(0, 2)),
            ($urandom_range(0, 99) < 30), 2'($urandom_range(0, 99) < 5 ? 3 : $urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
